// File: rtl/waffle_loader.sv
// -----------------------------------------------------------------------------
// waffle_loader
//
// Streams a row-major matrix of DATA_W-bit elements into the bank of column
// BRAMs used by the waffle engine. Element k of the stream lands in column
// BRAM (k % NUM_COLS) at row address (k / NUM_COLS). Once every location has
// been written, the loader raises load_done and pulses engine_start for one
// cycle. While loading, the loader owns write port A of every bank.
//
// If the source ends early (in_last before the final location), the remaining
// locations are filled with zeros, one per cycle, and len_err is set. If the
// final location is reached without in_last, len_err is also set. Any input
// offered after completion is refused through backpressure.
//
// Handshake: an element transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is a function of the FSM state only; it
// never looks at in_valid. in_data and in_last are only consumed on a
// transfer. The source must hold them stable while in_valid is high and
// in_ready is low.
//
// Ports
//   clk           in   single clock; all logic updates on the rising edge
//   rst           in   synchronous, active-high reset
//   load_start    in   pulse that begins a new load (honoured in IDLE/DONE)
//   in_valid      in   input element valid
//   in_data       in   input element, row-major order
//   in_last       in   source's final element
//   in_ready      out  loader accepts an element this cycle
//   bank_wren     out  one-hot write enable, bit c = column BRAM c (registered)
//   bank_addr     out  row address shared by all banks (registered)
//   bank_data     out  write data shared by all banks (registered)
//   load_done     out  matrix fully written; held until the next load_start
//   engine_start  out  one-cycle pulse, coincident with the final write
//   len_err       out  sticky: stream length differed from NUM_ROWS*NUM_COLS
//   dbg_state     out  current FSM state (0 IDLE, 1 LOAD, 2 FILL, 3 DONE)
// -----------------------------------------------------------------------------
module waffle_loader #(
    parameter int NUM_COLS = 256,
    parameter int NUM_ROWS = 512,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic [NUM_COLS-1:0] bank_wren,
    output logic [ADDR_W-1:0]   bank_addr,
    output logic [DATA_W-1:0]   bank_data,
    output logic                load_done,
    output logic                engine_start,
    output logic                len_err,
    output logic [1:0]          dbg_state
);

    // The column counter needs at least one bit, even for a single-column
    // configuration.
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // FSM and location counters. col_q/row_q always point at the next
    // location to be written.
    state_t              state_q,   state_d;
    logic [COL_W-1:0]    col_q,     col_d;
    logic [ADDR_W-1:0]   row_q,     row_d;

    // Registered write port and status outputs.
    logic [NUM_COLS-1:0] wren_q,    wren_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                done_q,    done_d;
    logic                start_q,   start_d;
    logic                len_err_q, len_err_d;

    // Combinational helpers.
    logic                at_final;
    logic                do_write;
    logic [DATA_W-1:0]   write_val;

    assign at_final = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wren_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            start_q   <= start_d;
            len_err_q <= len_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and write-port logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Defaults: hold state and counters, no write, no start pulse. The
        // address and data registers keep their last value between writes,
        // which only matters to a viewer, since wren gates every write.
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        wren_d    = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        start_d   = 1'b0;
        len_err_d = len_err_q;
        do_write  = 1'b0;
        write_val = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d   = S_LOAD;
                    col_d     = '0;
                    row_d     = '0;
                    done_d    = 1'b0;
                    len_err_d = 1'b0;
                end
            end

            S_LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone marks
                // a transfer. load_start is deliberately not looked at here.
                if (in_valid) begin
                    do_write  = 1'b1;
                    write_val = in_data;
                    if (at_final) begin
                        // The final location wins over an early-last check.
                        // The source should have flagged this element.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        start_d = 1'b1;
                        if (!in_last) begin
                            len_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // The source ran dry before the matrix was full.
                        // Zero-fill the rest.
                        state_d   = S_FILL;
                        len_err_d = 1'b1;
                    end
                end
            end

            S_FILL: begin
                // One zero write per cycle. The first one lands in the cycle
                // right after the short element's write, with no bubble.
                do_write  = 1'b1;
                write_val = '0;
                if (at_final) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    start_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_write) begin
            wren_d = NUM_COLS'(1) << col_q;
            addr_d = row_q;
            data_d = write_val;
            // Row-major walk: the column advances every write, and the row
            // advances when the column wraps. Any wrap past the final
            // location is harmless, because a new load clears both counters.
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = (state_q == S_LOAD);
    assign bank_wren    = wren_q;
    assign bank_addr    = addr_q;
    assign bank_data    = data_q;
    assign load_done    = done_q;
    assign engine_start = start_q;
    assign len_err      = len_err_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/waffle_loader.md
# waffle_loader

Streams a matrix of 32-bit signed values into the bank of column BRAMs used by the waffle engine, so the engine can run on fresh data at runtime instead of only on data preloaded at configuration. The loader accepts row-major elements on a valid/ready input stream and steers each one to the write port of its column BRAM at its row address. When every location has been written it pulses a start strobe to the engine. It owns write port A of every bank during loading; the engine must not issue reads until that strobe.

## Interface
- NUM_COLS, 256, number of column BRAMs (one per matrix column)
- NUM_ROWS, 512, rows per BRAM (addresses 0..NUM_ROWS-1)
- DATA_W, 32, element width
- ADDR_W, 9, BRAM address width; NUM_ROWS <= 2**ADDR_W
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse: begin a new load (honoured in IDLE or DONE only)
- in_valid  in  1  input element valid
- in_data  in  DATA_W  input element, row-major order
- in_last  in  1  marks final element supplied by the source
- in_ready  out  1  loader accepts an element this cycle
- bank_wren  out  NUM_COLS  one-hot write enable, bit c = column BRAM c
- bank_addr  out  ADDR_W  row address shared by all banks
- bank_data  out  DATA_W  write data shared by all banks
- load_done  out  1  matrix fully written; held until next load_start
- engine_start  out  1  one-cycle pulse to the engine when load completes
- len_err  out  1  sticky: stream length did not match NUM_ROWS*NUM_COLS

## Operation
- States: IDLE, LOAD, FILL, DONE. Reset -> IDLE, all outputs 0, col/row counters 0.
- IDLE/DONE + load_start -> LOAD. Counters cleared, load_done and len_err cleared.
- LOAD: in_ready = 1. Handshake = in_valid & in_ready. Each handshake writes in_data to bank col, address row. col increments. When col wraps from NUM_COLS-1 to 0, row increments.
- The final location is row NUM_ROWS-1, col NUM_COLS-1.
  - Handshake at the final location -> DONE. If in_last = 0 on that element, set len_err.
  - Handshake with in_last = 1 before the final location -> FILL and set len_err.
- FILL: in_ready = 0. Writes 0 to one location per cycle, continuing the same order, until the final location is written, then -> DONE.
- DONE: in_ready = 0, load_done = 1. Extra input is never accepted; the source sees backpressure.
- load_start is ignored in LOAD and FILL.
- in_ready depends on state only, never combinationally on in_valid.
- Data is passed unmodified; no arithmetic on elements. Counters are unsigned; col is ceil(log2 NUM_COLS) bits and row is ADDR_W bits.

## Timing
- Write outputs (bank_wren, bank_addr, bank_data) are registered.
  - A handshake at edge N produces bank_wren[col] = 1 with the matching addr/data during cycle N+1.
  - bank_wren is all-zero in any cycle with no write.
- Throughput: 1 element per cycle with in_valid held high. Gaps in in_valid produce gaps in bank_wren with no state change.
- Completion: the cycle in which the final write's bank_wren is high is also the first cycle of load_done = 1 and engine_start = 1. engine_start is high for exactly one cycle.
- Full load with no stalls takes NUM_ROWS*NUM_COLS cycles from the first handshake to the final write, plus one cycle of output latency.
- Early in_last at element k (0-based): the FILL zero writes follow back-to-back in the cycles immediately after element k's write, with no bubble.
- rst mid-load: on the next edge, state = IDLE, bank_wren = 0, in_ready = 0, load_done = 0, len_err = 0. Partially written BRAM contents are left as-is.
- load_start asserted in the same cycle as the final handshake is ignored; the loader still goes to DONE.

## Test plan
- Default params, 131072 elements with values 0,1,2,..., in_valid held high, in_last on the last element -> element k written to bank k%256, addr k/256, data k.
  - Final write: bank 255, addr 511, data 131071.
  - engine_start pulses once, in the same cycle as that write.
  - len_err = 0.
- NUM_COLS=4, NUM_ROWS=2; 8 elements 0x10..0x17 with in_valid toggling 1,0,1,0 -> bank_wren pattern mirrors the gaps, one cycle late; addresses 0,0,0,0,1,1,1,1; data 0x10..0x17 in order.
- NUM_COLS=4, NUM_ROWS=2; in_last on the 3rd element (0xA2) -> next 5 cycles write 0 to (col 3,row 0), (0,1), (1,1), (2,1), (3,1); in_ready = 0 during fill; len_err = 1; load_done = 1.
- NUM_COLS=4, NUM_ROWS=2; 8 elements with no in_last, then in_valid held high -> DONE with len_err = 1, in_ready stays 0, no further bank_wren; a new load_start clears len_err and load_done.
- rst asserted after 5 handshakes -> next cycle all outputs 0 and state IDLE. A new load_start plus 8 elements then writes from (col 0, row 0) again.
- load_start pulsed mid-LOAD, and again in the same cycle as the final handshake -> no counter reset; single engine_start; normal completion.
